spi_flash_loader: RTL and testbench
===================================

Name: spi_flash_loader

Overview:
- Wishbone master that copies a BIOS image from SPI NOR flash (S25FL064P, READ 0x03) into system RAM before the CPU fetches from it.
- Sits beside zet as a second initiator on the wb_switch master port (arbitrated externally); its Wishbone side issues write cycles toward the Base RAM slave.
- It drives its own dedicated SPI pins as SPI mode-0 master.
- busy can hold the CPU in reset during the load.

Parameters:
- SRC_ADDR, 24'h000000, flash byte address of the image start.
- DST_ADDR, 19'h78000, first RAM word address (wb_adr_o[19:1]); the default corresponds to byte address 0xF0000.
- LEN_WORDS, 16'd32768, number of 16-bit words to copy. 0 means no transfer.
- CLK_DIV, 8'd2, SCLK half-period in wb_clk_i cycles; must be at least 1.
- ACK_TIMEOUT, 8'd255, maximum number of wb_clk_i cycles to wait for wb_ack_i.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle load request
- busy  out  1  load in progress
- done  out  1  sticky completion flag
- error  out  1  sticky ack-timeout flag
- wb_dat_o  out  16  write data
- wb_adr_o  out  19  word address [19:1]
- wb_tga_o  out  1  always 0 (memory space)
- wb_sel_o  out  2  always 2'b11
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  slave acknowledge
- sclk  out  1  SPI clock
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- ss_n  out  1  flash chip select, active-low

Behaviour:
- Interface: one clock, wb_clk_i. Reset wb_rst_i is asynchronous and active-high.
- Reset values: sclk=0, mosi=0, ss_n=1, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_dat_o=0, wb_adr_o=DST_ADDR, busy=0, done=0, error=0, state IDLE.
- Reset asserted mid-load: all outputs return to reset values immediately. No resumption after reset.

SPI mode 0:
- sclk idles low.
- mosi is updated on the falling edge, or at bit start for the first bit.
- miso is sampled on the rising edge.
- Bits are MSB first.
- Each bit lasts 2*CLK_DIV clocks.

States:
- IDLE: on start=1, set busy=1 and clear done and error.
  - If LEN_WORDS==0, go to FINISH.
  - Otherwise go to SEL. start while busy is ignored.
- SEL: drive ss_n=0 and hold sclk low for CLK_DIV clocks, then go to CMD.
- CMD: shift out 32 bits: {8'h03, SRC_ADDR[23:0]}. Then go to RD_LO.
- RD_LO: clock in 8 bits into data[7:0]. Then go to RD_HI.
- RD_HI: clock in 8 bits into data[15:8] (little-endian word). Then go to WB.
- WB:
  - Assert wb_cyc_o, wb_stb_o and wb_we_o; wb_dat_o = assembled word. sclk is held low, ss_n stays 0, and the flash stream pauses.
  - Hold until wb_ack_i=1. On ack, deassert cyc/stb/we in the next cycle.
  - Then wb_adr_o increments by 1 (mod 2^19, wraps 19'h7FFFF to 0) and the word counter increments.
  - If count reaches LEN_WORDS, go to DESEL; otherwise go to RD_LO.
- WB timeout: if ack is absent for ACK_TIMEOUT consecutive cycles, deassert cyc/stb, set error=1, go to DESEL.
- DESEL: hold sclk low for CLK_DIV clocks, then set ss_n=1 and go to FINISH.
- FINISH: busy=0. done=1 only if error=0. Return to IDLE.

Flags and rules:
- done and error stay set until the next accepted start or reset.
- wb_ack_i outside state WB is ignored.
- Nominal time per word: 32*CLK_DIV + (ack latency + 1) clocks.
- Command phase: 64*CLK_DIV clocks.

Test Plan:
- CLK_DIV=1, LEN_WORDS=2, SRC_ADDR=24'h010000, flash model returns bytes 0x11,0x22,0x33,0x44; slave acks 1 cycle after stb.
  -> MOSI carries 0x03,0x01,0x00,0x00.
  -> Writes 0x2211 @DST_ADDR, then 0x4433 @DST_ADDR+1.
  -> ss_n rises after the last write; done=1, busy=0, error=0.
- LEN_WORDS=0, start pulse -> ss_n stays 1 and no cyc; busy high for 1 cycle, then done=1.
- Slave never acks, ACK_TIMEOUT=8 -> stb held exactly 8 cycles, then dropped; error=1, done=0, ss_n=1.
- DST_ADDR=19'h7FFFF, LEN_WORDS=2 -> second write at address 19'h00000.
- Assert wb_rst_i during the RD_HI phase of word 3 -> outputs at reset values in the same cycle. A new start afterwards reissues the 0x03 command from SRC_ADDR.
- start pulsed again while busy, CLK_DIV=3 -> ignored. Every sclk high and low phase measures 3 clocks; sclk stays low while stb is high.

Source files
------------

// File: rtl/spi_flash_loader.sv
// -----------------------------------------------------------------------------
// spi_flash_loader
// Copies a boot image from an SPI NOR flash (READ 0x03, SPI mode 0) into RAM
// through a Wishbone master write port. busy can hold the CPU in reset while
// the copy runs.
//
// Ports:
//   wb_clk_i, wb_rst_i   system clock, asynchronous active-high reset
//   start                one-cycle load request (ignored while busy)
//   busy, done, error    load in progress / sticky completion / sticky timeout
//   wb_dat_o, wb_adr_o   write data and RAM word address [19:1]
//   wb_tga_o, wb_sel_o   constant memory-space tag and full byte select
//   wb_we_o, wb_stb_o,
//   wb_cyc_o, wb_ack_i   Wishbone write handshake
//   sclk, mosi, miso,
//   ss_n                 SPI mode-0 master pins to the flash
// -----------------------------------------------------------------------------
module spi_flash_loader #(
    parameter logic [23:0] SRC_ADDR    = 24'h000000,
    parameter logic [18:0] DST_ADDR    = 19'h78000,
    parameter logic [15:0] LEN_WORDS   = 16'd32768,
    parameter logic [7:0]  CLK_DIV     = 8'd2,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] wb_dat_o,
    output logic [18:0] wb_adr_o,
    output logic        wb_tga_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        ss_n
);

    localparam logic [31:0] C_CMD = {8'h03, SRC_ADDR};

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_CMD, S_RD_LO, S_RD_HI, S_WB, S_DESEL, S_FINISH
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_div_cnt;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_word_cnt;
    logic [7:0]  r_to_cnt;
    logic [31:0] r_shift;
    logic [15:0] r_data;
    logic        r_sclk, r_mosi, r_ss_n, r_cyc, r_stb, r_we;
    logic [15:0] r_dat;
    logic [18:0] r_adr;
    logic        r_busy, r_done, r_error;

    logic w_div_end, w_shifting, w_rise, w_fall, w_bit_last, w_word_last, w_to_end;

    // One bit = a low half then a high half, each CLK_DIV clocks long; the
    // current sclk level tells which half we are in.
    assign w_div_end   = (r_div_cnt == CLK_DIV - 8'd1);
    assign w_shifting  = (r_state == S_CMD) || (r_state == S_RD_LO) || (r_state == S_RD_HI);
    assign w_rise      = w_shifting && !r_sclk && w_div_end;
    assign w_fall      = w_shifting &&  r_sclk && w_div_end;
    assign w_bit_last  = (r_bit_cnt == ((r_state == S_CMD) ? 5'd31 : 5'd7));
    assign w_word_last = ((r_word_cnt + 16'd1) == LEN_WORDS);
    assign w_to_end    = (r_to_cnt == ACK_TIMEOUT - 8'd1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = (LEN_WORDS == 16'd0) ? S_FINISH : S_SEL;
            S_SEL:    if (w_div_end) w_state_nxt = S_CMD;
            S_CMD:    if (w_fall && w_bit_last) w_state_nxt = S_RD_LO;
            S_RD_LO:  if (w_fall && w_bit_last) w_state_nxt = S_RD_HI;
            S_RD_HI:  if (w_fall && w_bit_last) w_state_nxt = S_WB;
            S_WB: begin
                if (wb_ack_i)      w_state_nxt = w_word_last ? S_DESEL : S_RD_LO;
                else if (w_to_end) w_state_nxt = S_DESEL;
            end
            S_DESEL:  if (w_div_end) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_to_cnt   <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss_n     <= 1'b1;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_dat      <= '0;
            r_adr      <= DST_ADDR;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Divider restarts on every state change and at every half-bit end,
            // so each state entry begins with a full low half.
            if ((w_state_nxt != r_state) || w_div_end) r_div_cnt <= '0;
            else                                       r_div_cnt <= r_div_cnt + 8'd1;

            if (w_state_nxt != r_state) r_bit_cnt <= '0;
            else if (w_fall)            r_bit_cnt <= r_bit_cnt + 5'd1;

            if (w_rise)      r_sclk <= 1'b1;
            else if (w_fall) r_sclk <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_word_cnt <= '0;
                        r_adr      <= DST_ADDR;
                        if (LEN_WORDS != 16'd0) r_ss_n <= 1'b0;
                    end
                end
                // First command bit is presented at bit start, later ones on falls.
                S_SEL: if (w_div_end) r_mosi <= C_CMD[31];
                S_CMD: if (w_fall)    r_mosi <= r_shift[31];
                S_RD_HI: begin
                    if (w_fall && w_bit_last) begin
                        r_cyc    <= 1'b1;
                        r_stb    <= 1'b1;
                        r_we     <= 1'b1;
                        r_dat    <= r_data;
                        r_to_cnt <= '0;
                    end
                end
                S_WB: begin
                    if (wb_ack_i) begin
                        r_cyc      <= 1'b0;
                        r_stb      <= 1'b0;
                        r_we       <= 1'b0;
                        r_adr      <= r_adr + 19'd1;
                        r_word_cnt <= r_word_cnt + 16'd1;
                    end else if (w_to_end) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                S_DESEL: if (w_div_end) r_ss_n <= 1'b1;
                S_FINISH: begin
                    r_busy <= 1'b0;
                    r_done <= ~r_error;
                end
                default: ;
            endcase
        end
    end

    // Shift registers carry no control meaning, so they need no reset.
    always_ff @(posedge wb_clk_i) begin
        if ((r_state == S_SEL) && w_div_end)  r_shift <= {C_CMD[30:0], 1'b0};
        else if ((r_state == S_CMD) && w_fall) r_shift <= {r_shift[30:0], 1'b0};
        if (w_rise && (r_state == S_RD_LO)) r_data[7:0]  <= {r_data[6:0], miso};
        if (w_rise && (r_state == S_RD_HI)) r_data[15:8] <= {r_data[14:8], miso};
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign wb_dat_o = r_dat;
    assign wb_adr_o = r_adr;
    assign wb_tga_o = 1'b0;
    assign wb_sel_o = 2'b11;
    assign wb_we_o  = r_we;
    assign wb_stb_o = r_stb;
    assign wb_cyc_o = r_cyc;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign ss_n     = r_ss_n;

endmodule

// File: tb/tb_spi_flash_loader.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_loader
// Three loader instances with different parameter sets share one clock:
//   A: CLK_DIV=1, LEN=4, SRC=0x010000, DST=0x7FFFE, ACK_TIMEOUT=8
//   B: LEN=0
//   C: CLK_DIV=3, LEN=2, defaults otherwise, randomly delayed acks
// Flash models hold random byte images; expected writes are derived from the
// image and the parameter set.
// -----------------------------------------------------------------------------
module tb_spi_flash_loader;

    typedef struct packed {
        logic [18:0] adr;
        logic [15:0] dat;
        logic        ss;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic ack_a = 1'b0, ack_b = 1'b0, ack_c = 1'b0;
    logic ack_en_a = 1'b0;

    logic        busy_a, done_a, err_a, tga_a, we_a, stb_a, cyc_a;
    logic        busy_b, done_b, err_b, tga_b, we_b, stb_b, cyc_b;
    logic        busy_c, done_c, err_c, tga_c, we_c, stb_c, cyc_c;
    logic [15:0] dat_a, dat_b, dat_c;
    logic [18:0] adr_a, adr_b, adr_c;
    logic [1:0]  sel_a, sel_b, sel_c;
    logic [1:0]  sclk_v, mosi_v, ss_v;
    wire  [1:0]  miso_v;
    logic        sclk_b, mosi_b, ss_b;

    logic [7:0]  fmem [2][256];
    wr_t         qa[$];
    wr_t         qc[$];

    spi_flash_loader #(.SRC_ADDR(24'h010000), .DST_ADDR(19'h7FFFE), .LEN_WORDS(16'd4),
                       .CLK_DIV(8'd1), .ACK_TIMEOUT(8'd8)) u_a (
        .wb_clk_i(clk), .wb_rst_i(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .error(err_a), .wb_dat_o(dat_a), .wb_adr_o(adr_a), .wb_tga_o(tga_a), .wb_sel_o(sel_a),
        .wb_we_o(we_a), .wb_stb_o(stb_a), .wb_cyc_o(cyc_a), .wb_ack_i(ack_a),
        .sclk(sclk_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]), .ss_n(ss_v[0]));

    spi_flash_loader #(.LEN_WORDS(16'd0)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .error(err_b), .wb_dat_o(dat_b), .wb_adr_o(adr_b), .wb_tga_o(tga_b), .wb_sel_o(sel_b),
        .wb_we_o(we_b), .wb_stb_o(stb_b), .wb_cyc_o(cyc_b), .wb_ack_i(ack_b),
        .sclk(sclk_b), .mosi(mosi_b), .miso(1'b0), .ss_n(ss_b));

    spi_flash_loader #(.LEN_WORDS(16'd2), .CLK_DIV(8'd3)) u_c (
        .wb_clk_i(clk), .wb_rst_i(rst_c), .start(start_c), .busy(busy_c), .done(done_c),
        .error(err_c), .wb_dat_o(dat_c), .wb_adr_o(adr_c), .wb_tga_o(tga_c), .wb_sel_o(sel_c),
        .wb_we_o(we_c), .wb_stb_o(stb_c), .wb_cyc_o(cyc_c), .wb_ack_i(ack_c),
        .sclk(sclk_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]), .ss_n(ss_v[1]));

    // Flash models: capture the command from the first 32 rising edges, then
    // stream the image MSB first, changing miso on falling edges.
    for (genvar g = 0; g < 2; g++) begin : g_flash
        int          frise = 0;
        int          ncmd  = 0;
        int          n;
        logic [31:0] cmd   = 32'h0;
        logic        miso_m = 1'b0;
        assign miso_v[g] = miso_m;

        always @(posedge sclk_v[g] or posedge ss_v[g]) begin
            if (ss_v[g]) begin
                frise = 0;
            end else begin
                if (frise < 32) cmd = {cmd[30:0], mosi_v[g]};
                frise = frise + 1;
                if (frise == 32) ncmd = ncmd + 1;
            end
        end

        always @(negedge sclk_v[g] or posedge ss_v[g]) begin
            if (ss_v[g]) begin
                miso_m = 1'b0;
            end else if (frise >= 32) begin
                n = frise - 32;
                miso_m = fmem[g][(n / 8) & 255][7 - (n % 8)];
            end
        end
    end

    // Slave A: acks one cycle after strobe rises, logs each acked write.
    bit  a_seen = 1'b0;
    wr_t wa;
    always @(negedge clk) begin
        if (stb_a && ack_en_a && !ack_a) begin
            if (a_seen) begin
                ack_a = 1'b1;
                wa = {adr_a, dat_a, ss_v[0]};
                qa.push_back(wa);
            end else begin
                a_seen = 1'b1;
            end
        end else if (!stb_a) begin
            ack_a  = 1'b0;
            a_seen = 1'b0;
        end
    end

    // Slave C: random ack latency.
    wr_t wc;
    always @(negedge clk) begin
        if (stb_c && !ack_c) begin
            if ($urandom_range(0, 2) == 0) begin
                ack_c = 1'b1;
                wc = {adr_c, dat_c, ss_v[1]};
                qc.push_back(wc);
            end
        end else if (!stb_c) begin
            ack_c = 1'b0;
        end
    end

    bit b_ss_seen = 1'b0, b_cyc_seen = 1'b0;
    always @(negedge clk) begin
        if (!ss_b)  b_ss_seen  = 1'b1;
        if (cyc_b)  b_cyc_seen = 1'b1;
    end

    // SPI phase timing monitor for instance C.
    int   run = 0, hi_cnt = 0, hi_bad = 0, lo_cnt = 0, lo_bad = 0, stb_sclk_bad = 0, c_falls = 0;
    bit   lo_ok = 1'b0;
    logic sclk_last = 1'b0, ss_last = 1'b1;
    always @(negedge clk) begin
        if (ss_last && !ss_v[1]) c_falls++;
        if (ss_v[1]) begin
            run   = 0;
            lo_ok = 1'b0;
        end else begin
            if (stb_c && sclk_v[1]) stb_sclk_bad++;
            if (sclk_v[1] == sclk_last) begin
                run++;
            end else begin
                if (sclk_last) begin
                    hi_cnt++;
                    if (run != 3) hi_bad++;
                    lo_ok = 1'b1;
                end else if (lo_ok) begin
                    lo_cnt++;
                    if (run != 3) lo_bad++;
                end
                run = 1;
            end
            if (stb_c) lo_ok = 1'b0;
        end
        sclk_last = sclk_v[1];
        ss_last   = ss_v[1];
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        tick(3);
        n_vec++;
        if ({sclk_v[0], mosi_v[0], ss_v[0], cyc_a, stb_a, we_a, busy_a, done_a, err_a} !== 9'b001000000) begin
            n_err++;
            $display("FAIL reset_a_ctrl got %b want 001000000",
                     {sclk_v[0], mosi_v[0], ss_v[0], cyc_a, stb_a, we_a, busy_a, done_a, err_a});
        end
        n_vec++;
        if (adr_a !== 19'h7FFFE || dat_a !== 16'h0) begin
            n_err++;
            $display("FAIL reset_a_bus got adr=%h dat=%h want adr=7fffe dat=0000", adr_a, dat_a);
        end
        n_vec++;
        if (adr_b !== 19'h78000 || ss_b !== 1'b1 || busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b got adr=%h ss=%b busy=%b want 78000 1 0", adr_b, ss_b, busy_b);
        end
        n_vec++;
        if (tga_a !== 1'b0 || sel_a !== 2'b11) begin
            n_err++;
            $display("FAIL const_tga_sel got tga=%b sel=%b want 0 11", tga_a, sel_a);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        tick(3);
        n_vec++;
        if (busy_a !== 1'b0 || ss_v[0] !== 1'b1 || cyc_a !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset got busy=%b ss=%b cyc=%b want 0 1 0", busy_a, ss_v[0], cyc_a);
        end
    endtask

    // Runs one full load on A and checks command, all writes and final flags.
    task automatic run_full_a(input string tag);
        int          base, nc0, cnt;
        logic [18:0] ea;
        logic [15:0] ed;
        base = qa.size();
        nc0  = g_flash[0].ncmd;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n_vec++;
        if (busy_a !== 1'b1 || done_a !== 1'b0 || err_a !== 1'b0) begin
            n_err++;
            $display("FAIL %s_accept got busy=%b done=%b err=%b want 1 0 0", tag, busy_a, done_a, err_a);
        end
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 4000) begin
            tick(1);
            cnt++;
        end
        n_vec++;
        if (busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL %s_timeout busy=%b after %0d cycles want 0", tag, busy_a, cnt);
        end
        n_vec++;
        if (g_flash[0].cmd !== 32'h03010000 || g_flash[0].ncmd !== nc0 + 1) begin
            n_err++;
            $display("FAIL %s_cmd got %h (x%0d) want 03010000 (x1)", tag, g_flash[0].cmd, g_flash[0].ncmd - nc0);
        end
        n_vec++;
        if (qa.size() - base !== 4) begin
            n_err++;
            $display("FAIL %s_nwrites got %0d want 4", tag, qa.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                ea = 19'h7FFFE + 19'(k);
                ed = {fmem[0][2*k+1], fmem[0][2*k]};
                n_vec++;
                if (qa[base+k].adr !== ea || qa[base+k].dat !== ed || qa[base+k].ss !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_write%0d got adr=%h dat=%h ss=%b want adr=%h dat=%h ss=0",
                             tag, k, qa[base+k].adr, qa[base+k].dat, qa[base+k].ss, ea, ed);
                end
            end
        end
        n_vec++;
        if (done_a !== 1'b1 || err_a !== 1'b0 || ss_v[0] !== 1'b1 || cyc_a !== 1'b0) begin
            n_err++;
            $display("FAIL %s_end got done=%b err=%b ss=%b cyc=%b want 1 0 1 0", tag, done_a, err_a, ss_v[0], cyc_a);
        end
    endtask

    task automatic test_load;
        int base;
        for (int i = 0; i < 256; i++) fmem[0][i] = 8'($urandom);
        fmem[0][0] = 8'h11;
        fmem[0][1] = 8'h22;
        fmem[0][2] = 8'h33;
        fmem[0][3] = 8'h44;
        ack_en_a = 1'b1;
        base = qa.size();
        run_full_a("load");
        n_vec++;
        if (qa.size() - base < 2 || qa[base].dat !== 16'h2211 || qa[base+1].dat !== 16'h4433) begin
            n_err++;
            $display("FAIL load_first_words got n=%0d want 2211 then 4433", qa.size() - base);
        end
    endtask

    task automatic test_timeout;
        int base, cnt, stb_cycles;
        ack_en_a = 1'b0;
        base = qa.size();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n_vec++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_accept got done=%b busy=%b want 0 1", done_a, busy_a);
        end
        cnt = 0;
        stb_cycles = 0;
        while (busy_a === 1'b1 && cnt < 2000) begin
            if (stb_a === 1'b1) stb_cycles++;
            tick(1);
            cnt++;
        end
        n_vec++;
        if (stb_cycles !== 8) begin
            n_err++;
            $display("FAIL timeout_stb_len got %0d cycles want 8", stb_cycles);
        end
        n_vec++;
        if (err_a !== 1'b1 || done_a !== 1'b0 || ss_v[0] !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_flags got err=%b done=%b ss=%b busy=%b want 1 0 1 0", err_a, done_a, ss_v[0], busy_a);
        end
        n_vec++;
        if (qa.size() !== base || stb_a !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_nowrite got writes=%0d stb=%b want 0 0", qa.size() - base, stb_a);
        end
    endtask

    task automatic test_reset_midload;
        int base, cnt;
        for (int i = 0; i < 256; i++) fmem[0][i] = 8'($urandom);
        ack_en_a = 1'b1;
        base = qa.size();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        cnt = 0;
        while (g_flash[0].frise < 75 && cnt < 4000) begin
            tick(1);
            cnt++;
        end
        n_vec++;
        if (g_flash[0].frise < 75 || qa.size() - base !== 2) begin
            n_err++;
            $display("FAIL midload_reach got rises=%0d writes=%0d want 75 2", g_flash[0].frise, qa.size() - base);
        end
        rst_a = 1'b1;
        #1;
        n_vec++;
        if ({sclk_v[0], mosi_v[0], ss_v[0], cyc_a, stb_a, we_a, busy_a, done_a, err_a} !== 9'b001000000
            || adr_a !== 19'h7FFFE || dat_a !== 16'h0) begin
            n_err++;
            $display("FAIL midload_reset got ctrl=%b adr=%h dat=%h want 001000000 7fffe 0000",
                     {sclk_v[0], mosi_v[0], ss_v[0], cyc_a, stb_a, we_a, busy_a, done_a, err_a}, adr_a, dat_a);
        end
        tick(1);
        rst_a = 1'b0;
        tick(20);
        n_vec++;
        if (busy_a !== 1'b0 || ss_v[0] !== 1'b1 || cyc_a !== 1'b0) begin
            n_err++;
            $display("FAIL midload_noresume got busy=%b ss=%b cyc=%b want 0 1 0", busy_a, ss_v[0], cyc_a);
        end
        run_full_a("restart");
    endtask

    task automatic test_zero_len;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        n_vec++;
        if (busy_b !== 1'b1 || done_b !== 1'b0) begin
            n_err++;
            $display("FAIL zero_busy got busy=%b done=%b want 1 0", busy_b, done_b);
        end
        tick(1);
        n_vec++;
        if (busy_b !== 1'b0 || done_b !== 1'b1 || err_b !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done got busy=%b done=%b err=%b want 0 1 0", busy_b, done_b, err_b);
        end
        tick(5);
        n_vec++;
        if (b_ss_seen !== 1'b0 || b_cyc_seen !== 1'b0) begin
            n_err++;
            $display("FAIL zero_quiet got ss_low=%b cyc=%b want 0 0", b_ss_seen, b_cyc_seen);
        end
    endtask

    task automatic test_back_to_back;
        int          base, nc0, f0, cnt;
        logic [18:0] ea;
        logic [15:0] ed;
        for (int i = 0; i < 256; i++) fmem[1][i] = 8'($urandom);
        base = qc.size();
        nc0  = g_flash[1].ncmd;
        f0   = c_falls;
        start_c = 1'b1;
        tick(1);
        start_c = 1'b0;
        tick(40 + $urandom_range(0, 200));
        start_c = 1'b1;
        tick(1);
        start_c = 1'b0;
        cnt = 0;
        while (busy_c === 1'b1 && cnt < 6000) begin
            tick(1);
            cnt++;
        end
        n_vec++;
        if (busy_c !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_timeout busy=%b after %0d cycles want 0", busy_c, cnt);
        end
        n_vec++;
        if (c_falls - f0 !== 1 || g_flash[1].ncmd - nc0 !== 1 || g_flash[1].cmd !== 32'h03000000) begin
            n_err++;
            $display("FAIL b2b_single got ss_falls=%0d cmds=%0d cmd=%h want 1 1 03000000",
                     c_falls - f0, g_flash[1].ncmd - nc0, g_flash[1].cmd);
        end
        n_vec++;
        if (qc.size() - base !== 2) begin
            n_err++;
            $display("FAIL b2b_nwrites got %0d want 2", qc.size() - base);
        end else begin
            for (int k = 0; k < 2; k++) begin
                ea = 19'h78000 + 19'(k);
                ed = {fmem[1][2*k+1], fmem[1][2*k]};
                n_vec++;
                if (qc[base+k].adr !== ea || qc[base+k].dat !== ed) begin
                    n_err++;
                    $display("FAIL b2b_write%0d got adr=%h dat=%h want adr=%h dat=%h",
                             k, qc[base+k].adr, qc[base+k].dat, ea, ed);
                end
            end
        end
        n_vec++;
        if (hi_cnt < 64 || hi_bad !== 0) begin
            n_err++;
            $display("FAIL clkdiv_high got phases=%0d bad=%0d want >=64 0", hi_cnt, hi_bad);
        end
        n_vec++;
        if (lo_cnt < 60 || lo_bad !== 0) begin
            n_err++;
            $display("FAIL clkdiv_low got phases=%0d bad=%0d want >=60 0", lo_cnt, lo_bad);
        end
        n_vec++;
        if (stb_sclk_bad !== 0) begin
            n_err++;
            $display("FAIL sclk_during_stb got %0d cycles want 0", stb_sclk_bad);
        end
        n_vec++;
        if (done_c !== 1'b1 || err_c !== 1'b0 || ss_v[1] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_end got done=%b err=%b ss=%b want 1 0 1", done_c, err_c, ss_v[1]);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_timeout();
        test_reset_midload();
        test_zero_len();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
